writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: entries per source FIFO, power of two, 2..8.
REQ-002 Parameter STARVE_LIMIT, default 3: consecutive ALU losses before ALU is forced to win, 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 alu_valid  input  1  ALU result beat offered.
REQ-006 alu_ready  output  1  ALU FIFO can accept a beat.
REQ-007 alu_rd  input  5  ALU destination register.
REQ-008 alu_data  input  32  ALU result.
REQ-009 lsu_valid  input  1  load result beat offered.
REQ-010 lsu_ready  output  1  LSU FIFO can accept a beat.
REQ-011 lsu_rd  input  5  load destination register.
REQ-012 lsu_data  input  32  load data.
REQ-013 reg_write_en_d  output  1  register-file write strobe, registered.
REQ-014 reg_write_addr_d  output  5  register-file write address, registered.
REQ-015 writeData  output  32  register-file write data, registered.
REQ-016 busy  output  1  any FIFO non-empty or reg_write_en_d high.

Function
REQ-017 A beat transfers on a rising edge where valid and ready are both high; ready does not depend on valid.
REQ-018 alu_ready = (ALU FIFO count < DEPTH); lsu_ready likewise; a full FIFO deasserts ready even in a cycle where it pops.
REQ-019 Beats with rd = 0 complete the handshake and are discarded; they never enter a FIFO and never raise reg_write_en_d.
REQ-020 Each FIFO preserves arrival order; no ordering is guaranteed between the two sources.
REQ-021 No input-to-output bypass: a beat accepted at edge k is at its FIFO head during cycle k+1 at the earliest.
REQ-022 Each cycle the arbiter selects at most one head: LSU if its head is valid, unless starve_cnt = STARVE_LIMIT and ALU head is valid, in which case ALU.
REQ-023 If only one head is valid it is selected; if none, nothing is selected.
REQ-024 Selected entry pops at the next edge; the same edge loads reg_write_en_d = 1, reg_write_addr_d = entry rd, writeData = entry data.
REQ-025 With no selection, next edge loads reg_write_en_d = 0; reg_write_addr_d and writeData hold their values.
REQ-026 Minimum latency: accepted at edge k -> reg_write_en_d high during cycle k+2 (after edge k+2... i.e. loaded at edge k+2).
REQ-027 starve_cnt (4-bit): increments, saturating at STARVE_LIMIT, on an edge where the ALU head is valid and LSU is selected; clears to 0 when ALU pops; holds otherwise.
REQ-028 Sustained throughput: one register write per cycle while any FIFO is non-empty.
REQ-029 Push and pop on the same FIFO in one edge (count < DEPTH) leave count unchanged; pointers wrap modulo DEPTH.
REQ-030 Same rd pending in both FIFOs: both writes issue in arbitration order; the issuing stage resolves such WAW hazards.

Reset
REQ-031 While rst_n = 0: FIFO counts and pointers 0, starve_cnt 0, reg_write_en_d 0, reg_write_addr_d 0, writeData 0, alu_ready 0, lsu_ready 0, busy 0.
REQ-032 Reset mid-operation discards all queued beats with no partial write; ready rises in the first cycle after rst_n deasserts.
REQ-033 FIFO storage arrays are not reset.

Verification
REQ-034 Single ALU beat rd=5, data=0x0000_1234 at edge 1 -> reg_write_en_d=1, addr=5, writeData=0x1234 after edge 3, low after edge 4.
REQ-035 Both sources valid every cycle (LSU rd=1..8, ALU rd=9..), STARVE_LIMIT=3 -> write order L,L,L,A,L,L,L,A; no cycle without a write.
REQ-036 Stall sink: push 3 ALU beats back-to-back, DEPTH=2 -> alu_ready low during cycle after 2nd accept while full; no beat lost; writes in order.
REQ-037 lsu_rd=0, data=0xFFFF_FFFF accepted -> reg_write_en_d never asserts, busy stays 0.
REQ-038 Assert rst_n=0 with 2 entries in each FIFO -> all outputs 0 immediately; after release, no write of stale entries.
REQ-039 Random valid/rd/data on both ports, 10k cycles -> scoreboard: every nonzero-rd beat written exactly once, per-source order preserved, ALU never waits more than STARVE_LIMIT losses.

Source files
------------

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// writeback_arbiter : two-source (ALU/LSU) register-file writeback arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------

module wb_src_fifo #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  logic [4:0]  i_rd,
   input  logic [31:0] i_data,
   input  logic        i_pop,
   output logic        o_ready,
   output logic        o_head_vld,
   output logic [4:0]  o_head_rd,
   output logic [31:0] o_head_data,
   output logic        o_nonempty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

   logic [4:0]       r_mem_rd   [DEPTH];
   logic [31:0]      r_mem_data [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fresh;

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem_rd[r_wr_ptr]   <= i_rd;
         r_mem_data[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_fresh  <= 1'b0;
      end else begin
         r_fresh <= i_push;
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // The entry written at the last edge is the tail; hiding it from the
   // arbiter for one cycle gives the two-edge minimum latency.
   assign o_head_vld  = (r_cnt > {{(CNT_W-1){1'b0}}, r_fresh});
   assign o_ready     = rst_n & (r_cnt < c_DEPTH);
   assign o_head_rd   = r_mem_rd[r_rd_ptr];
   assign o_head_data = r_mem_data[r_rd_ptr];
   assign o_nonempty  = (r_cnt != '0);
endmodule

module writeback_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   output logic        reg_write_en_d,
   output logic [4:0]  reg_write_addr_d,
   output logic [31:0] writeData,
   output logic        busy
);
   localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

   logic        w_alu_push, w_lsu_push;
   logic        w_alu_vld, w_lsu_vld;
   logic        w_alu_ne, w_lsu_ne;
   logic        w_sel_alu, w_sel_lsu;
   logic [4:0]  w_alu_head_rd, w_lsu_head_rd;
   logic [31:0] w_alu_head_data, w_lsu_head_data;
   logic [3:0]  r_starve_cnt;

   // rd = 0 beats still handshake but are dropped here.
   assign w_alu_push = alu_valid & alu_ready & (alu_rd != 5'd0);
   assign w_lsu_push = lsu_valid & lsu_ready & (lsu_rd != 5'd0);

   wb_src_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_alu_push),
      .i_rd        (alu_rd),
      .i_data      (alu_data),
      .i_pop       (w_sel_alu),
      .o_ready     (alu_ready),
      .o_head_vld  (w_alu_vld),
      .o_head_rd   (w_alu_head_rd),
      .o_head_data (w_alu_head_data),
      .o_nonempty  (w_alu_ne)
   );

   wb_src_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_lsu_push),
      .i_rd        (lsu_rd),
      .i_data      (lsu_data),
      .i_pop       (w_sel_lsu),
      .o_ready     (lsu_ready),
      .o_head_vld  (w_lsu_vld),
      .o_head_rd   (w_lsu_head_rd),
      .o_head_data (w_lsu_head_data),
      .o_nonempty  (w_lsu_ne)
   );

   // LSU has priority; ALU wins once it has lost STARVE_LIMIT times in a row.
   assign w_sel_alu = w_alu_vld & (~w_lsu_vld | (r_starve_cnt == c_LIMIT));
   assign w_sel_lsu = w_lsu_vld & ~w_sel_alu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt     <= 4'd0;
         reg_write_en_d   <= 1'b0;
         reg_write_addr_d <= 5'd0;
         writeData        <= 32'd0;
      end else begin
         if (w_sel_alu) begin
            r_starve_cnt     <= 4'd0;
            reg_write_en_d   <= 1'b1;
            reg_write_addr_d <= w_alu_head_rd;
            writeData        <= w_alu_head_data;
         end else if (w_sel_lsu) begin
            if (w_alu_vld && r_starve_cnt < c_LIMIT)
               r_starve_cnt <= r_starve_cnt + 4'd1;
            reg_write_en_d   <= 1'b1;
            reg_write_addr_d <= w_lsu_head_rd;
            writeData        <= w_lsu_head_data;
         end else begin
            reg_write_en_d <= 1'b0;
         end
      end
   end

   assign busy = w_alu_ne | w_lsu_ne | reg_write_en_d;
endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_writeback_arbiter : randomized bench with a timestamped-queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_writeback_arbiter;
   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, lsu_valid;
   logic        alu_ready, lsu_ready;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_data, lsu_data;
   logic        reg_write_en_d;
   logic [4:0]  reg_write_addr_d;
   logic [31:0] writeData;
   logic        busy;

   writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .alu_valid        (alu_valid),
      .alu_ready        (alu_ready),
      .alu_rd           (alu_rd),
      .alu_data         (alu_data),
      .lsu_valid        (lsu_valid),
      .lsu_ready        (lsu_ready),
      .lsu_rd           (lsu_rd),
      .lsu_data         (lsu_data),
      .reg_write_en_d   (reg_write_en_d),
      .reg_write_addr_d (reg_write_addr_d),
      .writeData        (writeData),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          edge_no;
   } ent_t;

   ent_t        aq[$];
   ent_t        lq[$];
   int          edge_no = 0;
   int          starve  = 0;
   logic        exp_we;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("we",   reg_write_en_d,   exp_we);
      check("addr", reg_write_addr_d, exp_addr);
      check("data", writeData,        exp_data);
      check("busy", busy, (aq.size() != 0 || lsu_q_nonempty() || exp_we));
   endtask

   function automatic bit lsu_q_nonempty();
      return lq.size() != 0;
   endfunction

   // One clock: inputs must already be driven; returns what was accepted.
   task automatic step(output bit a_acc, output bit l_acc);
      bit   a_rdy, l_rdy, a_vis, l_vis, sel_a, sel_l;
      ent_t e;
      @(negedge clk);
      a_rdy = (aq.size() < DEPTH);
      l_rdy = (lq.size() < DEPTH);
      check("alu_ready", alu_ready, a_rdy);
      check("lsu_ready", lsu_ready, l_rdy);
      // An entry pushed at the most recent edge is not yet eligible.
      a_vis = (aq.size() > 0) && (aq[0].edge_no < edge_no);
      l_vis = (lq.size() > 0) && (lq[0].edge_no < edge_no);
      sel_a = a_vis && (!l_vis || starve == STARVE_LIMIT);
      sel_l = l_vis && !sel_a;
      a_acc = alu_valid && a_rdy;
      l_acc = lsu_valid && l_rdy;
      @(posedge clk);
      edge_no++;
      if (sel_a) begin
         e = aq.pop_front();
         exp_we = 1'b1; exp_addr = e.rd; exp_data = e.data;
         starve = 0;
      end else if (sel_l) begin
         e = lq.pop_front();
         exp_we = 1'b1; exp_addr = e.rd; exp_data = e.data;
         if (a_vis && starve < STARVE_LIMIT) starve++;
      end else begin
         exp_we = 1'b0;
      end
      if (a_acc && alu_rd != 5'd0) aq.push_back('{alu_rd, alu_data, edge_no});
      if (l_acc && lsu_rd != 5'd0) lq.push_back('{lsu_rd, lsu_data, edge_no});
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      bit a, l;
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      for (int i = 0; i < n; i++) step(a, l);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_we",   reg_write_en_d,   1'b0);
      check("rst_addr", reg_write_addr_d, 5'd0);
      check("rst_data", writeData,        32'd0);
      check("rst_ardy", alu_ready,        1'b0);
      check("rst_lrdy", lsu_ready,        1'b0);
      check("rst_busy", busy,             1'b0);
      aq.delete(); lq.delete();
      starve = 0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      alu_valid = 1'b1; lsu_valid = 1'b1;
      alu_rd = 5'd7; lsu_rd = 5'd8;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_we",   reg_write_en_d, 1'b0);
      check("rst_hold_busy", busy,           1'b0);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit a, l;
      int cnt;
      rst_n = 1'b0;
      alu_valid = 1'b0; lsu_valid = 1'b0;
      alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
      exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      #3;
      check("init_we",   reg_write_en_d,   1'b0);
      check("init_addr", reg_write_addr_d, 5'd0);
      check("init_data", writeData,        32'd0);
      check("init_ardy", alu_ready,        1'b0);
      check("init_lrdy", lsu_ready,        1'b0);
      check("init_busy", busy,             1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Single ALU beat: written two edges after acceptance, one cycle wide.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
      step(a, l);
      check("single_acc", a, 1'b1);
      alu_valid = 1'b0;
      step(a, l);
      check("single_lat1", reg_write_en_d, 1'b0);
      step(a, l);
      check("single_we",   reg_write_en_d,   1'b1);
      check("single_addr", reg_write_addr_d, 5'd5);
      check("single_data", writeData,        32'h0000_1234);
      step(a, l);
      check("single_off",  reg_write_en_d,   1'b0);
      idle(2);

      // rd = 0 is accepted but never written.
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
      step(a, l);
      check("rd0_acc", l, 1'b1);
      idle(4);

      // Both sources continuously valid.
      for (int i = 0; i < 24; i++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(1 + (i % 8));  lsu_data = 32'h1000_0000 + i;
         alu_valid = 1'b1; alu_rd = 5'(9 + (i % 8));  alu_data = 32'hA000_0000 + i;
         step(a, l);
      end
      idle(8);

      // Three back-to-back ALU beats into a two-deep FIFO.
      cnt = 0;
      for (int i = 0; i < 20 && cnt < 3; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(cnt + 1); alu_data = 32'hB000_0000 + cnt;
         step(a, l);
         if (a) cnt++;
      end
      check("stall_accepts", cnt, 3);
      idle(8);

      // Reset with queued entries: nothing stale may be written afterwards.
      for (int i = 0; i < 4; i++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(20 + i); lsu_data = $urandom;
         alu_valid = 1'b1; alu_rd = 5'(24 + i); alu_data = $urandom;
         step(a, l);
      end
      do_reset();
      idle(6);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 10000; i++) begin
         if (i % 2500 == 1250) do_reset();
         alu_valid = ($urandom_range(0, 99) < 70);
         lsu_valid = ($urandom_range(0, 99) < 70);
         alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         alu_data  = $urandom;
         lsu_data  = $urandom;
         step(a, l);
      end
      idle(10);
      check("drain_alu", aq.size(), 0);
      check("drain_lsu", lq.size(), 0);
      check("drain_busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
